// File: rtl/riffa_rx_stream.sv
// RIFFA RX channel terminator: handshakes a receive transaction and emits its
// data as a valid/ready beat stream through a 2-entry buffer.
module riffa_rx_stream #(
  parameter int DW   = 64,
  parameter int LENW = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            chnl_rx_i,
  output logic            chnl_rx_ack_o,
  input  logic            chnl_rx_last_i,
  input  logic [LENW-1:0] chnl_rx_len_i,
  input  logic [30:0]     chnl_rx_off_i,
  input  logic [DW-1:0]   chnl_rx_data_i,
  input  logic            chnl_rx_data_valid_i,
  output logic            chnl_rx_data_ren_o,
  output logic            out_val_o,
  output logic [DW-1:0]   out_data_o,
  input  logic            out_rdy_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o
);

  localparam int unsigned L     = DW / 32;
  localparam int unsigned LOG2L = $clog2(L);
  localparam int unsigned TW    = (LOG2L > 0) ? LOG2L : 1;
  localparam int unsigned BW    = LENW + 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ACK     = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_WAITLOW = 3'd4;

  logic [2:0]    state;
  logic [2:0]    state_nx;
  logic [BW-1:0] beats_left;
  logic [BW-1:0] beats_calc;
  logic [TW-1:0] tail;
  logic [TW-1:0] tail_calc;
  logic          err;
  logic [DW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    occ;
  logic          push;
  logic          pop;
  logic          last_beat;
  logic [DW-1:0] push_data;
  logic          unused_last;

  // The last flag carries nothing the length does not already tell us.
  assign unused_last = &{1'b0, chnl_rx_last_i};

  // Widened by one bit so a near-maximal length cannot wrap the round-up.
  assign beats_calc = ({1'b0, chnl_rx_len_i} + BW'(L - 1)) >> LOG2L;
  assign tail_calc  = TW'(chnl_rx_len_i & LENW'(L - 1));

  assign chnl_rx_data_ren_o = (state == S_DATA) && (occ != 2'd2) && (beats_left != '0);
  assign push      = chnl_rx_data_ren_o && chnl_rx_data_valid_i;
  assign last_beat = push && (beats_left == BW'(1));
  assign pop       = (occ != 2'd0) && out_rdy_i;

  assign chnl_rx_ack_o = (state == S_ACK);
  assign busy_o        = (state != S_IDLE);
  assign done_o        = ((state == S_ACK) && (beats_left == '0)) || last_beat;
  assign err_o         = err;
  assign out_val_o     = (occ != 2'd0);
  assign out_data_o    = mem[rd_ptr];

  // Zero the lanes past the transaction length on the final beat.
  always_comb begin
    push_data = chnl_rx_data_i;
    if ((beats_left == BW'(1)) && (tail != '0)) begin
      for (int k = 0; k < int'(L); k++) begin
        if (32'(k) >= 32'(tail)) push_data[k*32 +: 32] = 32'd0;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (chnl_rx_i) state_nx = S_ACK;
      S_ACK:     state_nx = (beats_left != '0) ? S_DATA : S_WAITLOW;
      S_DATA:    if (last_beat) state_nx = S_DRAIN;
      S_DRAIN:   if (occ == 2'd0) state_nx = S_WAITLOW;
      S_WAITLOW: if (!chnl_rx_i) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Transaction counters, sticky error and the 2-entry beat buffer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beats_left <= '0;
      tail       <= '0;
      err        <= 1'b0;
      occ        <= 2'd0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      mem[0]     <= '0;
      mem[1]     <= '0;
    end else begin
      if ((state == S_IDLE) && chnl_rx_i) begin
        beats_left <= beats_calc;
        tail       <= tail_calc;
        if (chnl_rx_off_i != 31'd0) err <= 1'b1;
      end
      if (push) begin
        beats_left  <= beats_left - BW'(1);
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_riffa_rx_stream.sv
// Randomized scoreboard bench for riffa_rx_stream with a word-level reference model.
module tb_riffa_rx_stream;

  localparam int DW   = 64;
  localparam int L    = DW / 32;
  localparam int LENW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            chnl_rx;
  logic            ack;
  logic            chnl_rx_last;
  logic [LENW-1:0] len;
  logic [30:0]     off;
  logic [DW-1:0]   data;
  logic            valid;
  logic            ren;
  logic            out_val;
  logic [DW-1:0]   out_data;
  logic            out_rdy;
  logic            busy;
  logic            done;
  logic            err;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q [$];
  int rdy_mode = 0;
  bit err_model = 1'b0;

  riffa_rx_stream #(.DW(DW), .LENW(LENW)) dut (
    .clk_i(clk), .rst_i(rst),
    .chnl_rx_i(chnl_rx), .chnl_rx_ack_o(ack), .chnl_rx_last_i(chnl_rx_last),
    .chnl_rx_len_i(len), .chnl_rx_off_i(off), .chnl_rx_data_i(data),
    .chnl_rx_data_valid_i(valid), .chnl_rx_data_ren_o(ren),
    .out_val_o(out_val), .out_data_o(out_data), .out_rdy_i(out_rdy),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Downstream ready: 0 = always ready, 1 = random, 2 = stalled.
  initial begin
    out_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_rdy = 1'b1;
        1:       out_rdy = 1'($urandom_range(0, 1));
        default: out_rdy = 1'b0;
      endcase
    end
  end

  // Monitor: every delivered beat must match the oldest expected one.
  always @(negedge clk) begin
    if (!rst && out_val && out_rdy) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got %h required none", out_data);
      end else begin
        chk("beat", out_data, exp_q.pop_front());
      end
    end
  end

  task automatic do_txn(input int n, input logic [30:0] o, input int vmode,
                        input bit force_last, input int abort_at);
    int beats = (n + L - 1) / L;
    logic [DW-1:0] raw [$];
    logic [DW-1:0] expv [$];
    logic [DW-1:0] lat_exp = '0;
    bit lat_pending = 1'b0;
    bit aborted = 1'b0;
    int i = 0;
    int cyc = 0;
    int stall_cnt = 0;
    int w = 0;

    // Model: n 32-bit words packed lane 0 first; words past n read as zero.
    for (int b = 0; b < beats; b++) begin
      logic [DW-1:0] r;
      logic [DW-1:0] e;
      for (int k = 0; k < L; k++) r[k*32 +: 32] = $urandom;
      if (force_last && b == beats - 1) r = 64'hDEADBEEF_12345678;
      for (int k = 0; k < L; k++) e[k*32 +: 32] = (b * L + k < n) ? r[k*32 +: 32] : 32'd0;
      raw.push_back(r);
      expv.push_back(e);
    end

    @(posedge clk); #1;
    chnl_rx = 1'b1;
    len = LENW'(n);
    off = o;
    @(negedge clk);
    chk("ack_early", DW'(ack), '0);
    @(negedge clk);
    if (o != 31'd0) err_model = 1'b1;
    chk("ack", DW'(ack), DW'(1));
    chk("busy_ack", DW'(busy), DW'(1));
    chk("done_ack", DW'(done), DW'(n == 0));
    chk("ren_ack", DW'(ren), '0);
    chk("err_ack", DW'(err), DW'(err_model));

    while (i < beats && cyc < 300) begin
      @(posedge clk); #1;
      valid = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      data  = raw[i];
      @(negedge clk);
      cyc++;
      if (lat_pending) begin
        chk("lat_val", DW'(out_val), DW'(1));
        chk("lat_data", out_data, lat_exp);
      end
      lat_pending = 1'b0;
      if (rdy_mode == 2 && i == 2) begin
        stall_cnt++;
        if (stall_cnt == 1) begin
          chk("ren_full", DW'(ren), '0);
          chk("val_full", DW'(out_val), DW'(1));
        end
        if (stall_cnt == 3) rdy_mode = 0;
      end
      if (ren && valid) begin
        chk("done_last", DW'(done), DW'(i == beats - 1));
        exp_q.push_back(expv[i]);
        lat_pending = (rdy_mode == 0);
        lat_exp = expv[i];
        i++;
        if (abort_at != 0 && i == abort_at) begin
          aborted = 1'b1;
          break;
        end
      end else begin
        chk("done_idle", DW'(done), '0);
      end
    end

    if (aborted) begin
      @(posedge clk); #1;
      rst = 1'b1;
      chnl_rx = 1'b0;
      valid = 1'b0;
      exp_q.delete();
      err_model = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_outs", DW'({out_val, ren, ack, busy, done, err}), '0);
      repeat (3) @(negedge clk);
      chk("rst_quiet", DW'({out_val, ren, ack, busy, done}), '0);
      return;
    end
    if (i < beats) chk("data_timeout", DW'(i), DW'(beats));

    @(posedge clk); #1;
    chnl_rx = 1'b0;
    valid = 1'b0;
    @(negedge clk);
    if (lat_pending) begin
      chk("lat_val", DW'(out_val), DW'(1));
      chk("lat_data", out_data, lat_exp);
    end
    chk("ack_single", DW'(ack), '0);
    while (busy && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("busy_end", DW'(busy), '0);
    chk("drained", DW'(exp_q.size()), '0);
    chk("err_end", DW'(err), DW'(err_model));
    chk("ren_end", DW'(ren), '0);
  endtask

  initial begin
    rst = 1'b1;
    chnl_rx = 1'b0;
    chnl_rx_last = 1'b0;
    len = '0;
    off = '0;
    data = '0;
    valid = 1'b0;
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    chk("reset_ctrl", DW'({out_val, ren, ack, busy, done, err}), '0);
    chk("reset_data", out_data, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_txn(6, 31'd0, 0, 1'b0, 0);
    do_txn(5, 31'd0, 0, 1'b1, 0);
    do_txn(0, 31'd0, 0, 1'b0, 0);
    rdy_mode = 2;
    do_txn(8, 31'd0, 0, 1'b0, 0);
    rdy_mode = 0;
    do_txn(4, 31'd4, 0, 1'b0, 0);
    do_txn(3, 31'd0, 1, 1'b0, 0);
    do_txn(8, 31'd0, 0, 1'b0, 2);
    do_txn(2, 31'd0, 0, 1'b0, 0);

    for (int t = 0; t < 20; t++) begin
      rdy_mode = int'($urandom_range(0, 1));
      do_txn(int'($urandom_range(0, 13)),
             ($urandom_range(0, 7) == 0) ? 31'd2 : 31'd0, 1, 1'b0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
